// File: rtl/dw_mailbox_responder_if.sv
// ============================================================================
// Module      : dw_mailbox_responder_if
// Description : Data-bus and TX/RX stream signal bundle for the mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dw_mailbox_responder_if;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oHit;
  logic        oTxValid;
  logic [31:0] oTxData;
  logic        iTxReady;
  logic        iRxValid;
  logic [31:0] iRxData;
  logic        oRxReady;
  logic        oIrq;

  modport slave (
    input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    output oReadData, oHit,
    output oTxValid, oTxData, input iTxReady,
    input  iRxValid, iRxData, output oRxReady,
    output oIrq
  );

  modport master (
    output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    input  oReadData, oHit,
    input  oTxValid, oTxData, output iTxReady,
    output iRxValid, iRxData, input oRxReady,
    input  oIrq
  );
endinterface

`default_nettype wire

// File: rtl/dw_mailbox_responder.sv
// ============================================================================
// Module      : dw_mailbox_responder
// Description : CPU data-bus mailbox with TX/RX FIFOs and valid/ready streams.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dw_mailbox_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int          DEPTH     = 8,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  dw_mailbox_responder_if.slave bus
);

  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [1:0]    REG_TXDATA = 2'd0;
  localparam logic [1:0]    REG_RXDATA = 2'd1;
  localparam logic [1:0]    REG_STATUS = 2'd2;
  localparam logic [1:0]    REG_CTRL   = 2'd3;

  logic [31:0]   tx_mem_q [DEPTH];
  logic [31:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic          irq_en_q, irq_en_d;

  logic        w_hit;
  logic [1:0]  w_sel;
  logic        w_tx_wr, w_rx_rd, w_ctrl_wr;
  logic        w_clr_tx, w_clr_rx, w_clr_flags;
  logic        w_tx_nonempty, w_rx_nonempty;
  logic        w_pop_tx, w_push_tx, w_push_rx, w_pop_rx;
  logic        w_tx_mem_we, w_rx_mem_we;
  logic [31:0] w_tx_word, w_status, w_rdata;
  logic        w_unused_addr;

  assign w_hit = (bus.iAddress[31:4] == BASE_ADDR[31:4]);
  assign w_sel = bus.iAddress[3:2];
  assign w_unused_addr = ^bus.iAddress[1:0];

  assign w_tx_wr     = bus.iWriteEnable & w_hit & (w_sel == REG_TXDATA);
  assign w_rx_rd     = bus.iReadEnable  & w_hit & (w_sel == REG_RXDATA);
  assign w_ctrl_wr   = bus.iWriteEnable & w_hit & (w_sel == REG_CTRL) & bus.iByteEnable[0];
  assign w_clr_tx    = w_ctrl_wr & bus.iWriteData[0];
  assign w_clr_rx    = w_ctrl_wr & bus.iWriteData[1];
  assign w_clr_flags = w_ctrl_wr & bus.iWriteData[2];

  assign w_tx_nonempty = (tx_count_q != CNT_ZERO);
  assign w_rx_nonempty = (rx_count_q != CNT_ZERO);

  // A full TX FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop_tx  = w_tx_nonempty & bus.iTxReady;
  assign w_push_tx = w_tx_wr & ((tx_count_q != CNT_FULL) | w_pop_tx);
  assign w_push_rx = bus.iRxValid & bus.oRxReady;
  assign w_pop_rx  = w_rx_rd & w_rx_nonempty;

  assign w_tx_mem_we = w_push_tx & ~w_clr_tx;
  assign w_rx_mem_we = w_push_rx & ~w_clr_rx;

  assign w_tx_word = bus.iWriteData & {{8{bus.iByteEnable[3]}}, {8{bus.iByteEnable[2]}},
                                       {8{bus.iByteEnable[1]}}, {8{bus.iByteEnable[0]}}};

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (w_clr_tx) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end else begin
      if (w_push_tx) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
      if (w_pop_tx)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
      if (w_push_tx && !w_pop_tx)      tx_count_d = tx_count_q + CNT_ONE;
      else if (!w_push_tx && w_pop_tx) tx_count_d = tx_count_q - CNT_ONE;
    end
  end

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (w_clr_rx) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      if (w_push_rx) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
      if (w_pop_rx)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
      if (w_push_rx && !w_pop_rx)      rx_count_d = rx_count_q + CNT_ONE;
      else if (!w_push_rx && w_pop_rx) rx_count_d = rx_count_q - CNT_ONE;
    end
  end

  // Sticky flags: a new error in the clearing cycle keeps the flag set.
  always_comb begin
    tx_ovf_d = (tx_ovf_q & ~w_clr_flags) | (w_tx_wr & ~w_push_tx);
    rx_unf_d = (rx_unf_q & ~w_clr_flags) | (w_rx_rd & ~w_rx_nonempty);
    irq_en_d = w_ctrl_wr ? bus.iWriteData[3] : irq_en_q;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_ovf_q    <= 1'b0;
      rx_unf_q    <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_unf_q    <= rx_unf_d;
      irq_en_q    <= irq_en_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_tx_mem_we) tx_mem_q[tx_wr_ptr_q] <= w_tx_word;
    if (w_rx_mem_we) rx_mem_q[rx_wr_ptr_q] <= bus.iRxData;
  end

  assign w_status = {11'b0, irq_en_q, rx_unf_q, tx_ovf_q, ~w_rx_nonempty,
                     (tx_count_q == CNT_FULL), 8'(rx_count_q), 8'(tx_count_q)};

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_sel)
        REG_RXDATA: w_rdata = w_rx_nonempty ? rx_mem_q[rx_rd_ptr_q] : 32'h0;
        REG_STATUS: w_rdata = w_status;
        REG_CTRL:   w_rdata = {31'b0, irq_en_q};
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.oReadData = w_rdata;
  assign bus.oHit      = w_hit;
  assign bus.oTxValid  = w_tx_nonempty;
  assign bus.oTxData   = w_tx_nonempty ? tx_mem_q[tx_rd_ptr_q] : 32'h0;
  assign bus.oRxReady  = (rx_count_q != CNT_FULL);
  assign bus.oIrq      = irq_en_q & w_rx_nonempty;

endmodule

`default_nettype wire

// File: tb/tb_dw_mailbox_responder.sv
// ============================================================================
// Module      : tb_dw_mailbox_responder
// Description : Directed plus randomized bench with a queue-based mailbox model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dw_mailbox_responder;

  localparam logic [31:0] BASE  = 32'hFF20_0000;
  localparam int          DEPTH = 8;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;

  dw_mailbox_responder_if bus();

  dw_mailbox_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  // Mailbox state held as plain queues and flags.
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  bit          m_ovf, m_unf, m_irqen;

  function automatic bit m_hit();
    return bus.iAddress[31:4] == BASE[31:4];
  endfunction

  function automatic int m_sel();
    return int'(bus.iAddress[3:2]);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_txq.size()) + (32'(m_rxq.size()) << 8);
    if (m_txq.size() == DEPTH) s = s + (32'd1 << 16);
    if (m_rxq.size() == 0)     s = s + (32'd1 << 17);
    if (m_ovf)                 s = s + (32'd1 << 18);
    if (m_unf)                 s = s + (32'd1 << 19);
    if (m_irqen)               s = s + (32'd1 << 20);
    return s;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!m_hit()) return 32'h0;
    case (m_sel())
      1:       return (m_rxq.size() != 0) ? m_rxq[0] : 32'h0;
      2:       return m_status();
      3:       return m_irqen ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step();
    bit          wr_tx, rd_rx, ctrl, tx_pop, tx_ok, rx_push, rx_pop, ovf_new, unf_new;
    logic [31:0] word;
    int          txn, rxn;
    txn   = m_txq.size();
    rxn   = m_rxq.size();
    wr_tx = bus.iWriteEnable && m_hit() && m_sel() == 0;
    rd_rx = bus.iReadEnable  && m_hit() && m_sel() == 1;
    ctrl  = bus.iWriteEnable && m_hit() && m_sel() == 3 && bus.iByteEnable[0];
    word  = 32'h0;
    for (int b = 0; b < 4; b++)
      if (bus.iByteEnable[b]) word[b*8 +: 8] = bus.iWriteData[b*8 +: 8];
    tx_pop  = (txn > 0) && bus.iTxReady;
    tx_ok   = wr_tx && (txn < DEPTH || tx_pop);
    ovf_new = wr_tx && !tx_ok;
    rx_push = bus.iRxValid && (rxn < DEPTH);
    rx_pop  = rd_rx && (rxn > 0);
    unf_new = rd_rx && (rxn == 0);
    if (ctrl && bus.iWriteData[0]) m_txq.delete();
    else begin
      if (tx_pop) void'(m_txq.pop_front());
      if (tx_ok)  m_txq.push_back(word);
    end
    if (ctrl && bus.iWriteData[1]) m_rxq.delete();
    else begin
      if (rx_pop)  void'(m_rxq.pop_front());
      if (rx_push) m_rxq.push_back(bus.iRxData);
    end
    if (ctrl && bus.iWriteData[2]) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (ovf_new) m_ovf = 1'b1;
    if (unf_new) m_unf = 1'b1;
    if (ctrl) m_irqen = bus.iWriteData[3];
  endtask

  always @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      m_txq.delete();
      m_rxq.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_irqen = 1'b0;
    end else begin
      m_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    if (cmp_en) begin
      chk("hit",     32'(bus.oHit),     32'(m_hit()));
      chk("rdata",   bus.oReadData,     m_rdata());
      chk("txvalid", 32'(bus.oTxValid), 32'(m_txq.size() != 0));
      chk("txdata",  bus.oTxData,       (m_txq.size() != 0) ? m_txq[0] : 32'h0);
      chk("rxready", 32'(bus.oRxReady), 32'(m_rxq.size() < DEPTH));
      chk("irq",     32'(bus.oIrq),     32'(m_irqen && m_rxq.size() != 0));
    end
  end

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    bus.iReadEnable  = 1'b0;
    bus.iWriteEnable = 1'b0;
    bus.iByteEnable  = 4'h0;
    bus.iAddress     = 32'h0;
    bus.iWriteData   = 32'h0;
  endtask

  task automatic wr(input int r, input logic [31:0] d, input logic [3:0] be);
    bus.iWriteEnable = 1'b1;
    bus.iAddress     = BASE + 32'(r * 4);
    bus.iWriteData   = d;
    bus.iByteEnable  = be;
    cyc();
    idle();
  endtask

  task automatic rd_set(input int r);
    bus.iReadEnable = 1'b1;
    bus.iAddress    = BASE + 32'(r * 4);
  endtask

  task automatic stream_in(input logic [31:0] d);
    bus.iRxValid = 1'b1;
    bus.iRxData  = d;
    cyc();
    bus.iRxValid = 1'b0;
  endtask

  initial begin
    idle();
    bus.iTxReady = 1'b0;
    bus.iRxValid = 1'b0;
    bus.iRxData  = 32'h0;
    iRST = 1'b0;
    repeat (2) cyc();
    iRST = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    rd_set(2);
    #1;
    chk("t1_status", bus.oReadData, 32'h0002_0000);
    chk("t1_txvalid", 32'(bus.oTxValid), 32'h0);
    chk("t1_rxready", 32'(bus.oRxReady), 32'h1);
    chk("t1_irq", 32'(bus.oIrq), 32'h0);
    cyc();
    idle();

    // Fill TX to full, one overflow, then drain in order
    for (int i = 1; i <= 9; i++) wr(0, 32'h11 * i, 4'hF);
    rd_set(2);
    #1;
    chk("t2_status_full", bus.oReadData, 32'h0007_0008);
    cyc();
    idle();
    bus.iTxReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("t2_drain", bus.oTxData, 32'h11 * i);
      cyc();
    end
    #1;
    chk("t2_empty", 32'(bus.oTxValid), 32'h0);
    bus.iTxReady = 1'b0;
    cyc();
    wr(3, 32'h4, 4'h1);

    // Push into a full TX FIFO while its head drains
    for (int i = 1; i <= 8; i++) wr(0, 32'h100 + i, 4'hF);
    bus.iTxReady = 1'b1;
    wr(0, 32'hAA, 4'hF);
    bus.iTxReady = 1'b0;
    rd_set(2);
    #1;
    chk("t3_status", bus.oReadData, 32'h0003_0008);
    cyc();
    idle();
    bus.iTxReady = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      #1;
      chk("t3_drain", bus.oTxData, 32'h100 + i);
      cyc();
    end
    #1;
    chk("t3_last", bus.oTxData, 32'hAA);
    cyc();
    bus.iTxReady = 1'b0;

    // Byte-lane masking
    wr(0, 32'hDEAD_BEEF, 4'b0101);
    #1;
    chk("t4_mask", bus.oTxData, 32'h00AD_00EF);
    bus.iTxReady = 1'b1;
    cyc();
    bus.iTxReady = 1'b0;

    // RX stream, interrupt, pops and underflow
    stream_in(32'd5);
    stream_in(32'd6);
    wr(3, 32'h8, 4'h1);
    #1;
    chk("t5_irq_on", 32'(bus.oIrq), 32'h1);
    rd_set(1);
    #1;
    chk("t5_rd5", bus.oReadData, 32'd5);
    cyc();
    #1;
    chk("t5_rd6", bus.oReadData, 32'd6);
    cyc();
    idle();
    #1;
    chk("t5_irq_off", 32'(bus.oIrq), 32'h0);
    rd_set(1);
    #1;
    chk("t5_rd_empty", bus.oReadData, 32'h0);
    cyc();
    idle();
    rd_set(2);
    #1;
    chk("t5_status", bus.oReadData, 32'h001A_0000);
    cyc();
    idle();

    // Asynchronous reset in the middle of an RXDATA read
    wr(3, 32'h4, 4'h1);
    stream_in(32'h31);
    stream_in(32'h32);
    stream_in(32'h33);
    rd_set(1);
    #2;
    iRST = 1'b0;
    #1;
    chk("t6_rst_rxready", 32'(bus.oRxReady), 32'h1);
    chk("t6_rst_rdata", bus.oReadData, 32'h0);
    cyc();
    iRST = 1'b1;
    idle();
    rd_set(2);
    #1;
    chk("t6_status", bus.oReadData, 32'h0002_0000);
    cyc();
    idle();

    // Clear both FIFOs while a stream word is being offered
    wr(0, 32'h77, 4'hF);
    wr(0, 32'h78, 4'hF);
    stream_in(32'h41);
    bus.iRxValid = 1'b1;
    bus.iRxData  = 32'h42;
    wr(3, 32'h3, 4'h1);
    bus.iRxValid = 1'b0;
    rd_set(2);
    #1;
    chk("t6_clear", bus.oReadData, 32'h0002_0000);
    cyc();
    idle();

    // Randomized traffic: first phase fills, second phase drains
    for (int n = 0; n < 4000; n++) begin
      int          r;
      logic [31:0] d;
      r = int'($urandom_range(0, 15));
      bus.iReadEnable  = ($urandom_range(0, 2) == 0);
      bus.iWriteEnable = ($urandom_range(0, 1) == 0);
      bus.iByteEnable  = 4'($urandom);
      d = $urandom;
      if (r < 6)       bus.iAddress = BASE + 32'h0 + 32'($urandom_range(0, 3));
      else if (r < 10) bus.iAddress = BASE + 32'h4 + 32'($urandom_range(0, 3));
      else if (r < 12) bus.iAddress = BASE + 32'h8;
      else if (r < 13) begin
        bus.iAddress = BASE + 32'hC;
        if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
      end
      else if (r < 14) bus.iAddress = BASE + 32'h10 + 32'($urandom_range(0, 15));
      else             bus.iAddress = $urandom;
      bus.iWriteData = d;
      if (n < 2000) begin
        bus.iTxReady = ($urandom_range(0, 3) == 0);
        bus.iRxValid = ($urandom_range(0, 3) != 0);
      end else begin
        bus.iTxReady = ($urandom_range(0, 3) != 0);
        bus.iRxValid = ($urandom_range(0, 3) == 0);
      end
      bus.iRxData = $urandom;
      cyc();
    end
    idle();
    bus.iTxReady = 1'b0;
    bus.iRxValid = 1'b0;
    cyc();
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dw_mailbox_responder.md
Name: dw_mailbox_responder

Overview:
- Memory-mapped responder on the CPU data bus (DwReadEnable/DwWriteEnable/DwByteEnable/DwAddress/DwWriteData/DwReadData), i.e. the target side of the CPU's data-bus initiator port.
- Implements a bidirectional mailbox. CPU stores push words into a TX FIFO, which drains to a valid/ready stream. A valid/ready input stream fills an RX FIFO, which CPU loads pop.
- Read data is combinational from current state, so single-cycle, multicycle and pipeline cores all complete a load in the issuing cycle. All state changes happen on the clock edge.

Parameters:
- BASE_ADDR, 32'hFF20_0000: base of the 16-byte register window; must be 16-byte aligned.
- DEPTH, 8: entries per FIFO; power of two, 2..128.
- AW, $clog2(DEPTH): pointer width (derived).

Ports:
- iCLK, input, 1: clock; all state updates on the rising edge.
- iRST, input, 1: asynchronous, active-low reset.
- iReadEnable, input, 1: bus read strobe.
- iWriteEnable, input, 1: bus write strobe.
- iByteEnable, input, 4: byte lanes for writes.
- iAddress, input, 32: byte address.
- iWriteData, input, 32: store data.
- oReadData, output, 32: load data (combinational).
- oHit, output, 1: address is inside the window; used by the bus read mux.
- oTxValid, output, 1: TX FIFO not empty.
- oTxData, output, 32: TX FIFO head.
- iTxReady, input, 1: sink accepts the head this cycle.
- iRxValid, input, 1: source offers a word.
- iRxData, input, 32: offered word.
- oRxReady, output, 1: RX FIFO not full.
- oIrq, output, 1: level interrupt.

Behaviour:
- Decode:
  - oHit = (iAddress[31:4] == BASE_ADDR[31:4]).
  - Register select = iAddress[3:2]; iAddress[1:0] ignored.
  - Strobes without oHit have no effect. oReadData = 0 when oHit=0.
- Register map:
  - 0x0 TXDATA
    - Write: push {iWriteData lanes where iByteEnable=1, zero elsewhere}.
    - Read: returns 0, no side effect.
  - 0x4 RXDATA
    - Read: returns RX head, or 0 if empty. Pops on the clock edge closing the read cycle.
    - Write ignored.
  - 0x8 STATUS (read-only):
    - [7:0] tx_count
    - [15:8] rx_count
    - [16] tx_full
    - [17] rx_empty
    - [18] tx_overflow (sticky)
    - [19] rx_underflow (sticky)
    - [20] irq_en
    - other bits 0.
  - 0xC CTRL
    - Write acts only if iByteEnable[0]=1. bit0: clear TX; bit1: clear RX; bit2: clear sticky flags; bit3: irq_en is loaded from this bit.
    - Read returns {31'b0, irq_en}.
- FIFOs:
  - Circular buffer, AW-bit pointers plus (AW+1)-bit count.
  - Pointers wrap modulo DEPTH. Count range 0..DEPTH.
- TX side:
  - pop_tx = oTxValid & iTxReady.
  - A CPU push is accepted if tx_count<DEPTH, or if pop_tx occurs the same cycle (full FIFO with simultaneous pop: push accepted, count unchanged).
  - A rejected push sets tx_overflow; FIFO unchanged.
- RX side:
  - push_rx = iRxValid & oRxReady. oRxReady = (rx_count<DEPTH); it does not look ahead to a same-cycle pop.
  - A CPU RXDATA read with rx_count==0 returns 0 and sets rx_underflow. A same-cycle push_rx is still accepted; the new word is not returned that cycle.
  - Simultaneous push and pop on a non-empty RX FIFO: count unchanged.
- Clear precedence:
  - CTRL clear bits beat same-cycle push/pop on the same FIFO: pointers and count become 0, and the word offered that cycle is dropped.
  - In that cycle a stream handshake may still be visible on the port; the sink/source must treat it as completed.
  - Sticky flags: a clear in the same cycle as a new error leaves the flag set (set wins).
- oIrq = irq_en & (rx_count!=0), registered-state based (no combinational path from bus inputs).
- Reset (iRST=0, asynchronous, takes effect mid-transaction):
  - Pointers, counts, sticky flags and irq_en all 0.
  - Outputs after reset: oTxValid=0, oRxReady=1, oIrq=0.
  - oTxData and oReadData are 0 while empty/no hit. FIFO storage is not reset and is never visible while empty.
- Latency:
  - A CPU push is visible on oTxValid the next cycle.
  - A stream push is visible in STATUS/RXDATA the next cycle.

Test Plan:
1. Reset, then read 0x8 -> 32'h0002_0000 (rx_empty=1); oTxValid=0, oRxReady=1, oIrq=0.
2. With iTxReady=0: write 0x0 with 11,22,...,88 (BE=4'hF), then a ninth write 99 -> STATUS tx_count=8, tx_full=1, tx_overflow=1. Raise iTxReady -> oTxData sequence 11..88, then oTxValid=0.
3. TX full, iTxReady=1, CPU writes AA in the same cycle -> tx_count stays 8, no overflow; AA is eventually the last word out.
4. Write 0x0 data 32'hDEADBEEF with BE=4'b0101 -> oTxData=32'h00AD00EF.
5. Stream in 5,6 (iRxValid for two cycles), set irq_en (write 0xC=8) -> oIrq=1. Read 0x4 twice -> 5, then 6; oIrq=0 after the second pop. A third read -> 0 with rx_underflow=1.
6. Fill RX with 3 words, then assert iRST low mid-read of 0x4 -> counts 0, oRxReady=1; after release, STATUS=32'h0002_0000. Separately, a CTRL write of 3 during a stream push -> both counts 0.
